hood_display_driver: RTL and testbench

//  Output-side counterpart of the hood input stage. Takes the controller/timer status
//  (power, smoke level, clock, work time, hand-gesture countdown) and drives the board's
//  8-digit multiplexed 7-segment display. Scanning is time-multiplexed; page_next selects

---
 rtl/hood_display_driver_pkg.sv | 42 ++++
 rtl/hood_display_driver_seg7_glyph.sv | 12 +
 rtl/hood_display_driver.sv | 133 +++++++++++++
 tb/tb_hood_display_driver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hood_display_driver_pkg.sv
// Shared definitions for the hood 8-digit display driver: page codes, glyph table
// and the 6-bit binary to two-digit BCD helper.
package hood_display_driver_pkg;

  typedef enum logic [1:0] {
    PAGE_CLOCK = 2'd0,
    PAGE_WORK  = 2'd1,
    PAGE_HAND  = 2'd2
  } page_e;

  // Glyph codes 0..15 are the hex digits themselves.
  localparam logic [4:0] GLYPH_L     = 5'd16;
  localparam logic [4:0] GLYPH_U     = 5'd17;
  localparam logic [4:0] GLYPH_BLANK = 5'd18;
  localparam int         NUM_GLYPHS  = 19;

  // Segment patterns {g,f,e,d,c,b,a}, highest glyph code first.
  localparam logic [NUM_GLYPHS-1:0][6:0] GLYPH_SEG = {
    7'h00, 7'h3E, 7'h38,                      // blank, U, L
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, // F E d C b A
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,        // 9 8 7 6 5
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F         // 4 3 2 1 0
  };

  typedef struct packed {
    logic [4:0] code;
    logic       dp;
  } digit_t;

  // {tens, ones}; tens 0..6 built from 40/20/10 compare-and-subtract steps.
  function automatic logic [7:0] bin6_to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
    return {t, 4'(r)};
  endfunction

endpackage

// File: rtl/hood_display_driver_seg7_glyph.sv
// Glyph code to 7-segment pattern, purely combinational.
module hood_display_driver_seg7_glyph
  import hood_display_driver_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    if (code <= GLYPH_BLANK) seg = GLYPH_SEG[code];
  end
endmodule

// File: rtl/hood_display_driver.sv
// Multiplexed 8-digit 7-segment driver for the hood status pages
// (clock, work time, hand-gesture countdown).
module hood_display_driver
  import hood_display_driver_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int BLINK_HZ = 2
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       page_next,
  input  logic [3:0] state_smoke_lvl,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] work_hours,
  input  logic [5:0] work_minutes,
  input  logic [5:0] hand_time,
  output logic [7:0] seg_an,
  output logic [7:0] seg_out,
  output logic [1:0] page
);
  localparam int SCAN_DIV   = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic [2:0]    idx;
  logic          hand_nz_q;
  page_e         page_q, page_d;
  logic          scan_tc, refresh, hand_rise;
  logic [7:0]    bcd_hi, bcd_lo, bcd_hand;
  digit_t        dig;
  logic [6:0]    glyph_seg;
  logic [7:0]    new_an, new_seg, dig_an, dig_seg;

  assign scan_tc   = scan_cnt == SW'(SCAN_DIV - 1);
  // idx has just advanced when the scan counter is back at zero.
  assign refresh   = scan_cnt == '0;
  assign hand_rise = (hand_time != '0) && !hand_nz_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
      hand_nz_q <= 1'b0;
    end else begin
      scan_cnt  <= scan_tc ? '0 : scan_cnt + 1'b1;
      if (scan_tc) idx <= idx + 3'd1;
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      hand_nz_q <= hand_time != '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) page_q <= PAGE_CLOCK;
    else        page_q <= page_d;
  end

  // A fresh hand countdown overrides a coincident page_next.
  always_comb begin
    page_d = page_q;
    if (hand_rise) page_d = PAGE_HAND;
    else if (page_next) begin
      case (page_q)
        PAGE_CLOCK: page_d = PAGE_WORK;
        PAGE_WORK:  page_d = PAGE_HAND;
        default:    page_d = PAGE_CLOCK;
      endcase
    end
  end

  assign page     = page_q;
  assign bcd_hi   = bin6_to_bcd(page_q == PAGE_WORK ? work_hours   : cur_hour);
  assign bcd_lo   = bin6_to_bcd(page_q == PAGE_WORK ? work_minutes : cur_min);
  assign bcd_hand = bin6_to_bcd(hand_time);

  always_comb begin
    dig = '{code: GLYPH_BLANK, dp: 1'b0};
    if (page_q == PAGE_HAND) begin
      if (idx == 3'd1) dig.code = {1'b0, bcd_hand[7:4]};
      if (idx == 3'd0) dig.code = {1'b0, bcd_hand[3:0]};
      if (idx <= 3'd1 && hand_time != '0 && blink_off) dig.code = GLYPH_BLANK;
    end else begin
      case (idx)
        3'd7: dig.code = {1'b0, bcd_hi[7:4]};
        3'd6: begin dig.code = {1'b0, bcd_hi[3:0]}; dig.dp = 1'b1; end
        3'd5: dig.code = {1'b0, bcd_lo[7:4]};
        3'd4: dig.code = {1'b0, bcd_lo[3:0]};
        3'd1: if (page_q == PAGE_CLOCK) dig.code = GLYPH_L;
        3'd0: dig.code = (page_q == PAGE_CLOCK) ? {1'b0, state_smoke_lvl} : GLYPH_U;
        default: ;
      endcase
    end
  end

  hood_display_driver_seg7_glyph u_glyph (
    .code (dig.code),
    .seg  (glyph_seg)
  );

  assign new_an  = 8'b1 << idx;
  assign new_seg = {dig.dp, glyph_seg};

  // dig_* hold the digit sampled at refresh so power-up resumes without a glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_an  <= '0;
      dig_seg <= '0;
      seg_an  <= '0;
      seg_out <= '0;
    end else begin
      if (refresh) begin
        dig_an  <= new_an;
        dig_seg <= new_seg;
      end
      seg_an  <= power_on ? (refresh ? new_an  : dig_an)  : '0;
      seg_out <= power_on ? (refresh ? new_seg : dig_seg) : '0;
    end
  end

endmodule

// File: tb/tb_hood_display_driver.sv
// Scoreboard bench for hood_display_driver: 4-cycle digit scan, 48-cycle blink period.
module tb_hood_display_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       power_on = 1'b1;
  logic       page_next = 1'b0;
  logic [3:0] state_smoke_lvl = 4'd3;
  logic [5:0] cur_hour = 6'd12, cur_min = 6'd59;
  logic [5:0] work_hours = 6'd63, work_minutes = 6'd7;
  logic [5:0] hand_time = 6'd0;
  logic [7:0] seg_an, seg_out;
  logic [1:0] page;

  hood_display_driver #(.CLK_FREQ(48), .SCAN_HZ(12), .BLINK_HZ(1)) dut (
    .clk(clk), .reset(reset), .power_on(power_on), .page_next(page_next),
    .state_smoke_lvl(state_smoke_lvl), .cur_hour(cur_hour), .cur_min(cur_min),
    .work_hours(work_hours), .work_minutes(work_minutes), .hand_time(hand_time),
    .seg_an(seg_an), .seg_out(seg_out), .page(page)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    logic [15:0] v;
    string       nm;
  } exp_t;
  exp_t q[$];

  localparam logic [7:0] DP = 8'h80;

  function automatic logic [7:0] g(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      16: return 8'h38;                   // L
      17: return 8'h3E;                   // U
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout got queue %0d want 0", nm, q.size());
    q.delete();
  endtask

  // Monitor: every change of the digit enables is one presented output.
  initial begin
    logic [7:0] prev_an;
    exp_t e;
    prev_an = 8'h00;
    forever begin
      @(negedge clk);
      if (seg_an !== prev_an && q.size() > 0) begin
        e = q.pop_front();
        check(e.nm, {seg_an, seg_out}, e.v);
      end
      prev_an = seg_an;
    end
  end

  task automatic wait_first(input logic [7:0] val, output bit ok);
    logic [7:0] prev;
    prev = seg_an;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (seg_an == val && prev != val) begin ok = 1'b1; return; end
      prev = seg_an;
    end
    timeout("wait_digit");
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    timeout(nm);
  endtask

  // Expect the frame after the next appearance of digit 7; v[k] is digit k.
  task automatic frame(input logic [7:0][7:0] v, input bit blinky, input string nm);
    int m0;
    bit ok;
    logic [7:0] s;
    wait_first(8'h80, ok);
    if (!ok) return;
    m0 = (cyc - 1) / 4 + 1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      s = v[k];
      if (blinky && k < 2 && ((m0 + k) / 6) % 2 == 1) s = 8'h00;
      q.push_back('{v: {8'(1 << k), s}, nm: $sformatf("%s_d%0d", nm, k)});
    end
    wait_empty(nm);
  endtask

  task automatic pulse_page(input logic [1:0] want, input string nm);
    @(posedge clk); #1 page_next = 1'b1;
    @(posedge clk); #1 page_next = 1'b0;
    check(nm, {14'd0, page}, {14'd0, want});
  endtask

  logic [7:0][7:0] v_clk, v_work, v_hand9, v_hand0;

  initial begin
    int c, k;
    bit ok;
    v_clk   = {g(1), g(2) | DP, g(5), g(9), 8'h00, 8'h00, g(16), g(3)};
    v_work  = {g(6), g(3) | DP, g(0), g(7), 8'h00, 8'h00, 8'h00, g(17)};
    v_hand9 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, g(0), g(9)};
    v_hand0 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, g(0), g(0)};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {seg_an, seg_out}, 16'h0000);
    check("reset_page", {14'd0, page}, 16'd0);

    @(negedge clk) reset = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      @(posedge clk); #1;
      check($sformatf("scan_e%0d", e), {8'd0, seg_an}, {8'd0, 8'(1 << (((e - 1) / 4) % 8))});
      if (e == 1) check("first_d0", {8'd0, seg_out}, {8'd0, g(3)});
    end

    frame(v_clk, 1'b0, "clock");
    pulse_page(2'd1, "page_0to1");
    frame(v_work, 1'b0, "work");
    pulse_page(2'd2, "page_1to2");
    pulse_page(2'd0, "page_2to0");

    // Power off mid-scan, page_next still taken, then resume on the live idx.
    wait_first(8'h04, ok);
    @(posedge clk); #1;
    q.push_back('{v: 16'h0000, nm: "power_off"});
    power_on = 1'b0;
    pulse_page(2'd1, "off_page1");
    pulse_page(2'd2, "off_page2");
    pulse_page(2'd0, "off_page0");
    repeat (4) @(posedge clk);
    #1;
    c = cyc;
    k = (c / 4) % 8;
    q.push_back('{v: {8'(1 << k), v_clk[k]}, nm: "power_on"});
    power_on = 1'b1;
    wait_empty("power");

    hand_time = 6'd9;
    @(posedge clk); #1;
    check("hand_jump", {14'd0, page}, 16'd2);
    frame(v_hand9, 1'b1, "hand9_a");
    frame(v_hand9, 1'b1, "hand9_b");
    frame(v_hand9, 1'b1, "hand9_c");
    hand_time = 6'd0;
    frame(v_hand0, 1'b0, "hand0_a");
    frame(v_hand0, 1'b0, "hand0_b");

    pulse_page(2'd0, "page_hand_to0");
    @(posedge clk); #1;
    page_next = 1'b1;
    hand_time = 6'd5;
    @(posedge clk); #1;
    page_next = 1'b0;
    check("jump_beats_next", {14'd0, page}, 16'd2);

    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_rst_out", {seg_an, seg_out}, 16'h0000);
    check("async_rst_page", {14'd0, page}, 16'd0);
    hand_time = 6'd0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("restart_d0", {seg_an, seg_out}, {8'h01, g(3)});
    check("restart_page", {14'd0, page}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
